dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port round-robin arbiter in front of the single-port word data memory (`dmem`: combinational read, synchronous write, 64 words). Port 0 is the CPU load/store path and port 1 is the secondary master (debug/DMA loader). The block accepts one request per grant, drives the memory for exactly one cycle, and returns a registered response. Each accepted access is alignment- and range-checked before it reaches the memory.

## Interface
Parameters:
- `DEPTH`, 64: memory depth in words; word index is `addr[31:2]`.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `m0_req`, `m1_req`  in  1  request valid; held until granted.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  32  byte address.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_gnt`, `m1_gnt`  out  1  accept strobe, combinational; the request transfers on a clock edge where `req & gnt`.
- `m0_rvalid`, `m1_rvalid`  out  1  one-cycle response pulse, registered.
- `m0_rdata`, `m1_rdata`  out  32  read data; valid only with `rvalid`.
- `m0_err`, `m1_err`  out  1  access rejected; valid only with `rvalid`.
- `mem_we`  out  1  to `dmem.we`.
- `mem_a`  out  32  to `dmem.a`.
- `mem_wd`  out  32  to `dmem.wd`.
- `mem_rd`  in  32  from `dmem.rd`.

## Operation
- FSM has two states. In IDLE, one of the pending requests may be granted. In ACCESS, memory is driven from the latched request.
- IDLE → ACCESS on any grant. ACCESS → IDLE always.
- Grant rule:
  - Only in IDLE and not `reset`.
  - A single requester wins.
  - If both request, the port not granted last wins.
  - Priority pointer `last` resets to 1, so port 0 wins the first contested round. It updates on every grant.
- At accept, the block latches `{port, we, addr, wdata}`.
- Error check at accept: `err = (addr[1:0] != 0) | (addr[31:2] >= DEPTH)`.
- In ACCESS:
  - `mem_a` = latched addr; `mem_wd` = latched wdata.
  - `mem_we = latched_we & ~err & ~reset`.
  - At the end of the cycle, `mem_rd` is captured for the owning port.
- Response (cycle after ACCESS):
  - Only the owning port's `rvalid` is 1.
  - `err` as latched.
  - `rdata = mem_rd` for a good read; 0 for writes and errored accesses.
- Outside ACCESS: `mem_we = 0`; `mem_a`/`mem_wd` hold the last latched values, with no glitching toward the memory.
- A requester must keep `req`/`we`/`addr`/`wdata` stable until `gnt`. It may drop `req` before grant (no access occurs).

## Timing
- Accept at edge E0 (cycle C0 has `req & gnt`). ACCESS is cycle C1, with the write committed at edge E1. `rvalid` is high during C2.
- Latency is 2 cycles from accept to response. Peak throughput is one access per 2 cycles.
- A new grant may occur in C2, concurrent with the previous `rvalid`.
- Back-to-back contention alternates ports: 0, 1, 0, 1…
- A read following a write to the same address returns the new data, because the write commits before the next ACCESS.
- Reset values: state = IDLE, `last` = 1, all `gnt`/`rvalid`/`err` = 0, all `rdata` = 0, `mem_we` = 0, `mem_a` = 0, `mem_wd` = 0.
- Reset asserted in ACCESS:
  - No memory write that cycle (`mem_we` gated).
  - No `rvalid` follows.
  - The in-flight request is dropped; the master must reissue.
- Reset asserted in the `rvalid` cycle: pulse is still visible that cycle; cleared next edge.
- `gnt` is never asserted while `reset` = 1.

## Structure
- `dmem_arb_pkg` holds:
  - state encodings `S_IDLE`, `S_ACCESS`;
  - port indices `P0`, `P1`;
  - default `DEPTH`.
- Sub-module `rr_arb2`: 2-way round-robin.
  - Inputs: `req[1:0]`, `last`, `en`.
  - Output: one-hot `gnt[1:0]`.
  - Purely combinational; the `last` register stays in the parent.
- The top level holds the FSM, request latch, error check and response registers. Target is roughly 150–200 lines.

## Test plan
- Single write then read, port 0: write `addr=0x10`, `wdata=0xDEADBEEF`. Then read `0x10`. Required: `m0_rvalid` two cycles after each accept, `m0_rdata=0xDEADBEEF`, `m0_err=0`.
- Contention: both ports hold `req` for 8 cycles with distinct reads. Required: grants 0, 1, 0, 1; each `gnt` exactly 2 cycles apart; `rvalid` only on the owning port.
- Errors:
  - Port 1 writes `addr=0x13`, then `addr=0x100` (word 64). Required: `m1_err=1`, `rdata=0`, `mem_we` never 1.
  - A later read of word 4 (`0x10`) is unchanged.
- Reset in ACCESS: port 0 writes `0x5555AAAA` to `0x20`, with `reset` high during C1. Required: no `rvalid`, word 8 (`0x20`) unchanged, all outputs at reset values, next contested grant goes to port 0.
- Same-address write/read back-to-back, cross-port: port 1 writes `0x20 ← 0x12345678` while port 0 queues a read of `0x20`. Required: port 0 reads `0x12345678`.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter: state and port
// encodings, the latched request record and the access legality check.
package dmem_arb_pkg;

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_ACCESS = 1'b1;

   localparam logic P0 = 1'b0;
   localparam logic P1 = 1'b1;

   localparam int unsigned DEFAULT_DEPTH = 64;

   typedef struct packed {
      logic        port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
   } req_t;

   // An access is rejected when it is not word aligned or its word index
   // falls beyond the end of the memory.
   function automatic logic addr_error(input logic [31:0] addr, input int unsigned depth);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant: a lone requester always wins,
// a contested round goes to the port that was not granted last.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   input  logic       en,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter in front of the single-port data memory: accepts one
// request at a time, drives the memory for one cycle, returns a registered response.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   output logic        m0_err,

   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        m1_err,

   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   logic [0:0]  state_q, state_d;
   logic        lastPort_q, lastPort_d;
   req_t        cur_q, cur_d;
   logic [1:0]  rvalid_q, rvalid_d;
   logic [1:0]  rspErr_q, rspErr_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] rdata1_q, rdata1_d;

   logic [1:0]  gnt;
   logic        grantEn;
   logic        accessing;
   logic        accepted;
   logic        selPort;
   logic        selWe;
   logic [31:0] selAddr;
   logic [31:0] selWdata;

   assign accessing = (state_q == S_ACCESS);
   assign grantEn   = (state_q == S_IDLE) && !reset;

   rr_arb2 u_rr (
      .req  ({m1_req, m0_req}),
      .last (lastPort_q),
      .en   (grantEn),
      .gnt  (gnt)
   );

   assign m0_gnt   = gnt[0];
   assign m1_gnt   = gnt[1];
   assign accepted = |gnt;

   assign selPort  = gnt[1] ? P1 : P0;
   assign selWe    = gnt[1] ? m1_we    : m0_we;
   assign selAddr  = gnt[1] ? m1_addr  : m0_addr;
   assign selWdata = gnt[1] ? m1_wdata : m0_wdata;

   // IDLE latches the winner; ACCESS turns the memory result into a response.
   always_comb begin
      state_d    = state_q;
      lastPort_d = lastPort_q;
      cur_d      = cur_q;
      rvalid_d   = 2'b00;
      rspErr_d   = 2'b00;
      rdata0_d   = '0;
      rdata1_d   = '0;

      if (accessing) begin
         state_d                 = S_IDLE;
         rvalid_d[cur_q.port]    = 1'b1;
         rspErr_d[cur_q.port]    = cur_q.err;
         if (!cur_q.we && !cur_q.err) begin
            if (cur_q.port == P1) begin
               rdata1_d = mem_rd;
            end else begin
               rdata0_d = mem_rd;
            end
         end
      end else if (accepted) begin
         state_d     = S_ACCESS;
         lastPort_d  = selPort;
         cur_d.port  = selPort;
         cur_d.we    = selWe;
         cur_d.addr  = selAddr;
         cur_d.wdata = selWdata;
         cur_d.err   = addr_error(selAddr, DEPTH);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         lastPort_q <= P1;
         cur_q      <= '0;
         rvalid_q   <= 2'b00;
         rspErr_q   <= 2'b00;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         state_q    <= state_d;
         lastPort_q <= lastPort_d;
         cur_q      <= cur_d;
         rvalid_q   <= rvalid_d;
         rspErr_q   <= rspErr_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
      end
   end

   // Address and data come straight from the latch so the memory never sees
   // them change between accesses; only the write strobe is qualified.
   assign mem_a     = cur_q.addr;
   assign mem_wd    = cur_q.wdata;
   assign mem_we    = accessing && cur_q.we && !cur_q.err && !reset;

   assign m0_rvalid = rvalid_q[0];
   assign m1_rvalid = rvalid_q[1];
   assign m0_err    = rspErr_q[0];
   assign m1_err    = rspErr_q[1];
   assign m0_rdata  = rdata0_q;
   assign m1_rdata  = rdata1_q;

endmodule
